// File: rtl/hls_mon_pkg.sv
// Shared types and frame-geometry helpers for the HLS output monitor.
package hls_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_NEXT  = 2'd3
  } mon_state_e;

  localparam int HDR_W = 8;

  function automatic int frame_bits(input int cnt_w, input int data_w, input bit hdr_en);
    return cnt_w + data_w + (hdr_en ? HDR_W : 0);
  endfunction

  function automatic int frame_beats(input int cnt_w, input int data_w, input bit hdr_en,
                                     input int out_w);
    return frame_bits(cnt_w, data_w, hdr_en) / out_w;
  endfunction

endpackage

// File: rtl/hls_mon_ch_acc.sv
// One channel's running write count / modular data sum, plus the snapshot taken at ap_done.
module hls_mon_ch_acc #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              write,
  input  logic [DATA_W-1:0] din,
  input  logic              clear,
  input  logic              snap_en,
  output logic [CNT_W-1:0]  snap_cnt,
  output logic [DATA_W-1:0] snap_sum
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] sum_nxt;

  // A write coinciding with clear still belongs to the ending execution, so the
  // snapshot takes the post-write values.
  always_comb begin
    cnt_nxt = cnt;
    sum_nxt = sum;
    if (write) begin
      sum_nxt = sum + din;
      if (cnt != '1) begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt      <= '0;
      sum      <= '0;
      snap_cnt <= '0;
      snap_sum <= '0;
    end else begin
      if (clear) begin
        cnt <= '0;
        sum <= '0;
      end else begin
        cnt <= cnt_nxt;
        sum <= sum_nxt;
      end
      if (snap_en) begin
        snap_cnt <= cnt_nxt;
        snap_sum <= sum_nxt;
      end
    end
  end

endmodule

// File: rtl/hls_out_monitor.sv
// Taps every output channel of the HLS kernel, accumulates per-execution count/sum and
// streams the snapshot out in OUT_W-bit beats. Define MON_FRAME_HDR_EN to add a frame header.
//
// state | meaning
// IDLE  | no dump in progress, waiting for ap_done
// LOAD  | load frame of channel ch_idx into the shift register
// SHIFT | present top beat, advance on dump_ready
// NEXT  | step to next channel, or wrap to channel 0 and go idle
module hls_out_monitor
  import hls_mon_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 16,
  parameter int EXE_W      = 6,
  parameter int EXE_TARGET = 2,
  parameter int OUT_W      = 4
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_din,
  input  logic                     ap_done,
  input  logic                     dump_ready,
  output logic [OUT_W-1:0]         data_out,
  output logic                     data_valid,
  output logic                     busy,
  output logic [EXE_W-1:0]         exe_cnt,
  output logic                     overrun,
  output logic                     finish
);

`ifdef MON_FRAME_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FRAME_W = frame_bits(CNT_W, DATA_W, HDR_EN);
  localparam int BEATS   = frame_beats(CNT_W, DATA_W, HDR_EN, OUT_W);
  localparam int BC_W    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_LOAD  = ST_LOAD;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_NEXT  = ST_NEXT;

  localparam logic [CH_W-1:0]  LAST_CH    = CH_W'(NUM_CH - 1);
  localparam logic [BC_W-1:0]  BEAT_LAST  = BC_W'(BEATS - 1);
  localparam logic [EXE_W-1:0] EXE_TGT    = EXE_W'(EXE_TARGET);

  logic [1:0]         state;
  logic [CH_W-1:0]    ch_idx;
  logic [BC_W-1:0]    beat_left;
  logic [FRAME_W-1:0] shreg;
  logic [FRAME_W-1:0] frame_load;
  logic               snap_en;

  logic [CNT_W-1:0]   snap_cnt [NUM_CH];
  logic [DATA_W-1:0]  snap_sum [NUM_CH];

  // A dump in flight keeps its snapshot; a late ap_done only flags overrun.
  assign snap_en = ap_done && (state == S_IDLE);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    hls_mon_ch_acc #(
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W)
    ) u_acc (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .write    (ch_write[g]),
      .din      (ch_din[g*DATA_W +: DATA_W]),
      .clear    (ap_done),
      .snap_en  (snap_en),
      .snap_cnt (snap_cnt[g]),
      .snap_sum (snap_sum[g])
    );
  end

`ifdef MON_FRAME_HDR_EN
  logic [3:0] dump_exe;

  // Index of the execution being dumped is the pre-increment count.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      dump_exe <= '0;
    end else if (snap_en) begin
      dump_exe <= 4'(exe_cnt);
    end
  end

  assign frame_load = {dump_exe, 4'(ch_idx), snap_cnt[ch_idx], snap_sum[ch_idx]};
`else
  assign frame_load = {snap_cnt[ch_idx], snap_sum[ch_idx]};
`endif

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= S_IDLE;
      ch_idx    <= '0;
      beat_left <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (snap_en) begin
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          shreg     <= frame_load;
          beat_left <= BEAT_LAST;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (dump_ready) begin
            shreg <= shreg << OUT_W;
            if (beat_left == '0) begin
              state <= S_NEXT;
            end else begin
              beat_left <= beat_left - 1'b1;
            end
          end
        end
        S_NEXT: begin
          if (ch_idx == LAST_CH) begin
            ch_idx <= '0;
            state  <= S_IDLE;
          end else begin
            ch_idx <= ch_idx + 1'b1;
            state  <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      exe_cnt <= '0;
      overrun <= 1'b0;
      finish  <= 1'b0;
    end else begin
      if (ap_done && (exe_cnt != '1)) begin
        exe_cnt <= exe_cnt + 1'b1;
      end
      if (ap_done && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      if ((state == S_IDLE) && !ap_done && (exe_cnt >= EXE_TGT)) begin
        finish <= 1'b1;
      end
    end
  end

  assign data_out   = shreg[FRAME_W-1 -: OUT_W];
  assign data_valid = (state == S_SHIFT);
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_hls_out_monitor.sv
// Directed bench for hls_out_monitor with a queue-based model of the expected beat stream.
module tb_hls_out_monitor;

`ifdef MON_FRAME_HDR_EN
  localparam int FB    = 14;
  localparam int HB    = 2;
  localparam int TOTAL = 112;
`else
  localparam int FB    = 12;
  localparam int HB    = 0;
  localparam int TOTAL = 96;
`endif

  logic         ap_clk;
  logic         ap_rst_n;
  logic [7:0]   ch_write;
  logic [255:0] ch_din;
  logic         ap_done;
  logic         dump_ready;
  logic [3:0]   data_out;
  logic         data_valid;
  logic         busy;
  logic [5:0]   exe_cnt;
  logic         overrun;
  logic         finish;

  hls_out_monitor #(
    .NUM_CH     (8),
    .DATA_W     (32),
    .CNT_W      (16),
    .EXE_W      (6),
    .EXE_TARGET (2),
    .OUT_W      (4)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .ch_write   (ch_write),
    .ch_din     (ch_din),
    .ap_done    (ap_done),
    .dump_ready (dump_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .exe_cnt    (exe_cnt),
    .overrun    (overrun),
    .finish     (finish)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_sum [8];
  logic [15:0] m_cnt [8];
  int          m_exe;
  logic        m_overrun;
  logic [3:0]  exp_q [$];
  int          exp_rd = 0;
  logic [3:0]  rec [1024];
  int          rec_n = 0;
  int          rec_base = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every presented beat must be the next one the model expects; held until accepted.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      exp_rd = exp_q.size();
    end else if (data_valid) begin
      if (exp_rd >= exp_q.size()) begin
        chk("unexpected_beat", data_valid, 1'b0);
      end else begin
        chk("beat", data_out, exp_q[exp_rd]);
        if (dump_ready) begin
          rec[rec_n % 1024] = data_out;
          rec_n++;
          exp_rd++;
        end
      end
      chk("busy_with_valid", busy, 1'b1);
    end
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin
      m_sum[k] = '0;
      m_cnt[k] = '0;
    end
    m_exe     = 0;
    m_overrun = 1'b0;
  endtask

  task automatic push_frames();
    logic [55:0] f;
    for (int k = 0; k < 8; k++) begin
      f = {4'(m_exe), 4'(k), m_cnt[k], m_sum[k]};
      for (int i = 0; i < FB; i++) exp_q.push_back(4'(f >> (4 * (FB - 1 - i))));
    end
  endtask

  // One cycle of stimulus: optional write on channel ch, optional ap_done.
  task automatic wr(input int ch, input logic [31:0] d, input logic done);
    ch_write = '0;
    ch_din   = '0;
    if (ch >= 0) begin
      ch_write[ch]         = 1'b1;
      ch_din[ch*32 +: 32]  = d;
    end
    ap_done = done;
    tick();
    ch_write = '0;
    ch_din   = '0;
    ap_done  = 1'b0;
    if (ch >= 0) begin
      m_sum[ch] = m_sum[ch] + d;
      if (m_cnt[ch] != 16'hFFFF) m_cnt[ch] = m_cnt[ch] + 16'd1;
    end
    if (done) begin
      if (exp_rd != exp_q.size()) m_overrun = 1'b1;
      else push_frames();
      for (int k = 0; k < 8; k++) begin
        m_sum[k] = '0;
        m_cnt[k] = '0;
      end
      if (m_exe != 63) m_exe++;
    end
  endtask

  task automatic drain(input bit toggle);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (toggle) dump_ready = ~dump_ready;
      if ((exp_rd == exp_q.size()) && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    dump_ready = 1'b1;
    chk("drain_done", ok, 1'b1);
    tick();
    tick();
  endtask

  task automatic wait_beats(input int n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (rec_n - rec_base >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_beats", ok, 1'b1);
  endtask

  task automatic do_reset();
    ap_rst_n   = 1'b0;
    ch_write   = '0;
    ch_din     = '0;
    ap_done    = 1'b0;
    dump_ready = 1'b1;
    model_clear();
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [47:0] frame_of(input int ch);
    logic [47:0] f;
    f = '0;
    for (int i = 0; i < 12; i++) f = {f[43:0], rec[(rec_base + ch*FB + HB + i) % 1024]};
    return f;
  endfunction

  task automatic chk_status(input string tag);
    chk({tag, "_exe_cnt"}, exe_cnt, 64'(m_exe));
    chk({tag, "_overrun"}, overrun, m_overrun);
  endtask

  initial begin
    // T1: basic accumulation, wrap, latency and frame layout
    do_reset();
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_data", data_out, 4'h0);
    chk("rst_exe", exe_cnt, 6'd0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_finish", finish, 1'b0);
    rec_base = rec_n;
    wr(0, 32'h1, 1'b0);
    wr(0, 32'h2, 1'b0);
    wr(0, 32'h3, 1'b0);
    wr(5, 32'hFFFF_FFFF, 1'b0);
    wr(5, 32'hFFFF_FFFF, 1'b0);
    wr(-1, 32'h0, 1'b1);
    chk("lat_cycle1_valid", data_valid, 1'b0);
    chk("lat_cycle1_busy", busy, 1'b1);
    tick();
    chk("lat_cycle2_valid", data_valid, 1'b1);
    drain(1'b0);
    chk("t1_beats", rec_n - rec_base, TOTAL);
    chk("t1_ch0", frame_of(0), 48'h0003_0000_0006);
    chk("t1_ch5", frame_of(5), 48'h0002_FFFF_FFFE);
    chk("t1_ch3", frame_of(3), 48'h0);
    chk("t1_exe_lit", exe_cnt, 6'd1);
    chk("t1_finish", finish, 1'b0);
    chk_status("t1");

    // T2: write coinciding with ap_done belongs to the ending execution
    do_reset();
    rec_base = rec_n;
    wr(2, 32'h10, 1'b1);
    drain(1'b0);
    chk("t2a_ch2", frame_of(2), 48'h0001_0000_0010);
    chk("t2a_finish", finish, 1'b0);
    rec_base = rec_n;
    wr(2, 32'h5, 1'b0);
    wr(-1, 32'h0, 1'b1);
    drain(1'b0);
    chk("t2b_ch2", frame_of(2), 48'h0001_0000_0005);
    chk("t2b_beats", rec_n - rec_base, TOTAL);
    chk("t2b_finish", finish, 1'b1);
`ifdef MON_FRAME_HDR_EN
    chk("hdr_ch6_b0", rec[(rec_base + 6*FB) % 1024], 4'h1);
    chk("hdr_ch6_b1", rec[(rec_base + 6*FB + 1) % 1024], 4'h6);
`endif
    chk_status("t2");

    // T3: dump_ready toggling every cycle
    do_reset();
    rec_base = rec_n;
    wr(1, 32'hDEAD_BEEF, 1'b0);
    wr(7, 32'h0000_1000, 1'b0);
    wr(7, 32'h0000_2000, 1'b0);
    wr(4, 32'h8000_0001, 1'b0);
    wr(-1, 32'h0, 1'b1);
    drain(1'b1);
    chk("t3_beats", rec_n - rec_base, TOTAL);
    chk("t3_ch1", frame_of(1), 48'h0001_DEAD_BEEF);
    chk("t3_ch7", frame_of(7), 48'h0002_0000_3000);
    chk("t3_ch4", frame_of(4), 48'h0001_8000_0001);
    chk_status("t3");

    // T4: ap_done during ch3 dump
    do_reset();
    rec_base = rec_n;
    wr(3, 32'hAB, 1'b0);
    wr(0, 32'h11, 1'b0);
    wr(-1, 32'h0, 1'b1);
    chk("t4_overrun_pre", overrun, 1'b0);
    wait_beats(3*FB + 2);
    wr(4, 32'h77, 1'b1);
    chk("t4_overrun", overrun, 1'b1);
    chk("t4_exe_lit", exe_cnt, 6'd2);
    chk("t4_finish_early", finish, 1'b0);
    chk_status("t4a");
    drain(1'b0);
    chk("t4_beats", rec_n - rec_base, TOTAL);
    chk("t4_ch0", frame_of(0), 48'h0001_0000_0011);
    chk("t4_ch3", frame_of(3), 48'h0001_0000_00AB);
    chk("t4_ch4", frame_of(4), 48'h0);
    chk("t4_finish", finish, 1'b1);
    rec_base = rec_n;
    wr(-1, 32'h0, 1'b1);
    drain(1'b0);
    chk("t4_cleared_ch4", frame_of(4), 48'h0);
    chk_status("t4b");

    // T5: reset mid-dump, then a clean run
    do_reset();
    rec_base = rec_n;
    wr(0, 32'h9, 1'b0);
    wr(-1, 32'h0, 1'b1);
    wait_beats(40);
    #2;
    ap_rst_n = 1'b0;
    model_clear();
    #1;
    chk("t5_rst_valid", data_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    chk("t5_rst_data", data_out, 4'h0);
    chk("t5_rst_exe", exe_cnt, 6'd0);
    tick();
    tick();
    ap_rst_n = 1'b1;
    tick();
    rec_base = rec_n;
    wr(0, 32'h1234, 1'b0);
    wr(6, 32'h42, 1'b0);
    wr(-1, 32'h0, 1'b1);
    drain(1'b0);
    chk("t5_beats", rec_n - rec_base, TOTAL);
    chk("t5_ch0", frame_of(0), 48'h0001_0000_1234);
    chk("t5_ch6", frame_of(6), 48'h0001_0000_0042);
    chk_status("t5");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
